// File: rtl/tree_adder_pkg.sv
// tree_adder_pkg: rounding-mode encodings and elaboration helpers shared by the adder tree.
package tree_adder_pkg;

    typedef enum logic [1:0] {
        MODE_FLOOR = 2'b00,
        MODE_RHU   = 2'b01,
        MODE_RTZ   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pipe_add_level.sv
// pipe_add_level: one registered tree level summing adjacent signed pairs at full width.
module pipe_add_level #(
    parameter int N_PAIR = 16,
    parameter int IN_W   = 36
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [1:0]                   in_mode,
    input  logic [2*N_PAIR*IN_W-1:0]     in_data,
    output logic                         out_valid,
    output logic [1:0]                   out_mode,
    output logic [N_PAIR*(IN_W+1)-1:0]   out_data
);
    localparam int OW = IN_W + 1;

    logic                 valid_d, valid_q;
    logic [1:0]           mode_d, mode_q;
    logic [N_PAIR*OW-1:0] sum_d, sum_q;

    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        if (en) begin
            valid_d = in_valid;
            mode_d  = in_mode;
            for (int k = 0; k < N_PAIR; k++)
                sum_d[k*OW +: OW] = OW'($signed(in_data[2*k*IN_W +: IN_W]))
                                  + OW'($signed(in_data[(2*k+1)*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mode_q  <= '0;
            sum_q   <= '0;
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_data  = sum_q;

endmodule

// File: rtl/pipe_tree_adder.sv
// pipe_tree_adder: pipelined signed adder tree with rounding, saturation and global-stall handshake.
module pipe_tree_adder
    import tree_adder_pkg::*;
#(
    parameter int N_IN  = 32,
    parameter int IN_W  = 36,
    parameter int OUT_W = 32,
    parameter int SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_ovf
);
    localparam int L  = clog2(N_IN);
    localparam int SW = IN_W + L;
    localparam int EW = SW + 1;
    localparam logic [EW-1:0] LSB    = EW'(1) << SHIFT;
    localparam logic [EW-1:0] HALF   = LSB >> 1;
    localparam logic [EW-1:0] LSB_M1 = LSB - EW'(1);
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    if (N_IN < 2 || N_IN > 64 || (1 << L) != N_IN) begin : g_bad_n
        $error("N_IN must be a power of two in 2..64");
    end
    if (SHIFT < 0 || SHIFT > IN_W || OUT_W > SW - SHIFT) begin : g_bad_w
        $error("SHIFT or OUT_W out of range");
    end

    logic en;
    logic out_valid_d, out_valid_q;
    logic out_ovf_d, out_ovf_q;
    logic [OUT_W-1:0] out_data_d, out_data_q;

    // Every stage moves together: the whole pipe stalls only when the output is held.
    assign en       = out_ready || !out_valid_q;
    assign in_ready = en;

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int W  = IN_W + l;
        localparam int NP = N_IN >> (l + 1);
        logic [2*NP*W-1:0]   din;
        logic                din_valid;
        logic [1:0]          din_mode;
        logic [NP*(W+1)-1:0] dout;
        logic                dout_valid;
        logic [1:0]          dout_mode;
        if (l == 0) begin : g_first
            assign din       = in_data;
            assign din_valid = in_valid;
            assign din_mode  = in_mode;
        end else begin : g_next
            assign din       = g_lvl[l-1].dout;
            assign din_valid = g_lvl[l-1].dout_valid;
            assign din_mode  = g_lvl[l-1].dout_mode;
        end
        pipe_add_level #(.N_PAIR(NP), .IN_W(W)) u_lvl (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .in_valid  (din_valid),
            .in_mode   (din_mode),
            .in_data   (din),
            .out_valid (dout_valid),
            .out_mode  (dout_mode),
            .out_data  (dout)
        );
    end

    logic [SW-1:0] tree_sum;
    logic          tree_valid;
    logic [1:0]    tree_mode;
    logic signed [EW-1:0] ext, bias, rnd;

    assign tree_sum   = g_lvl[L-1].dout;
    assign tree_valid = g_lvl[L-1].dout_valid;
    assign tree_mode  = g_lvl[L-1].dout_mode;

    // Rounding is a bias added before the arithmetic shift; one spare bit keeps it exact.
    always_comb begin
        ext  = EW'($signed(tree_sum));
        bias = tree_mode == MODE_RHU ? HALF : (tree_mode == MODE_RTZ && ext < 0) ? LSB_M1 : '0;
        rnd  = (ext + bias) >>> SHIFT;
        out_valid_d = en ? tree_valid : out_valid_q;
        out_ovf_d   = en ? (rnd > SAT_MAX || rnd < SAT_MIN) : out_ovf_q;
        out_data_d  = !en ? out_data_q :
                      rnd > SAT_MAX ? SAT_MAX[OUT_W-1:0] :
                      rnd < SAT_MIN ? SAT_MIN[OUT_W-1:0] : rnd[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ovf   = out_ovf_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pipe_tree_adder.sv
// tb_pipe_tree_adder: directed and scoreboarded checks of the pipelined tree adder.
module tb_pipe_tree_adder;
    localparam int N  = 32;
    localparam int W  = 36;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [1:0]    in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_ovf;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int n_out, first_out, last_out;
    bit sb_on = 1'b0;
    bit hold = 1'b0;
    logic [31:0] hold_d;
    logic        hold_o;
    logic [32:0] exp_q[$];

    pipe_tree_adder #(.N_IN(N), .IN_W(W), .OUT_W(32), .SHIFT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [W-1:0] a);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = a;
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        logic [63:0] r;
        logic [W-1:0] a;
        for (int k = 0; k < N; k++) begin
            r = {$urandom, $urandom};
            a = r[W-1:0];
            a = $signed(a) >>> $urandom_range(0, 4);
            v[k*W +: W] = a;
        end
        return v;
    endfunction

    // Reference: exact integer sum, divide by 256 with explicit floor/truncate handling, then clamp.
    function automatic logic [32:0] model(input logic [VW-1:0] v, input logic [1:0] m);
        longint s, q, r, res;
        logic [W-1:0] a;
        s = 0;
        for (int k = 0; k < N; k++) begin
            a = v[k*W +: W];
            s += longint'($signed(a));
        end
        if (m == 2'b01) s += 128;
        q = s / 256;
        r = s % 256;
        res = (m == 2'b10 || r >= 0) ? q : q - 1;
        if (res > 64'sh7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
        if (res < -64'sh80000000) return {1'b1, 32'h80000000};
        return {1'b0, res[31:0]};
    endfunction

    task automatic send_one(input string tag, input logic [VW-1:0] v, input logic [1:0] m,
                            input logic [31:0] exp_d, input logic exp_o);
        int cyc;
        in_data = v;
        in_mode = m;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 6);
        check({tag, "_d"}, out_data, exp_d);
        check({tag, "_o"}, out_ovf, exp_o);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            if (hold) begin
                check("hold_v", out_valid, 1);
                check("hold_d", out_data, hold_d);
                check("hold_o", out_ovf, hold_o);
            end
            check("in_ready", in_ready, out_ready || !out_valid);
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_mode));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_result", 1, 0);
                else check("result", {out_ovf, out_data}, exp_q.pop_front());
                if (n_out == 0) first_out = cyc_cnt;
                last_out = cyc_cnt;
                n_out++;
            end
            hold = out_valid && !out_ready;
            hold_d = out_data;
            hold_o = out_ovf;
        end else hold = 1'b0;
    end

    initial begin
        int cyc, stale;
        bit acc;
        logic [W-1:0] a;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 2'b00;
        out_ready = 1'b1;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        send_one("all256", fill(36'd256), 2'b00, 32'd32, 1'b0);
        a = 36'd384;
        send_one("p384_m0", {{(VW-W){1'b0}}, a}, 2'b00, 32'd1, 1'b0);
        send_one("p384_m1", {{(VW-W){1'b0}}, a}, 2'b01, 32'd2, 1'b0);
        send_one("p384_m2", {{(VW-W){1'b0}}, a}, 2'b10, 32'd1, 1'b0);
        send_one("p384_m3", {{(VW-W){1'b0}}, a}, 2'b11, 32'd1, 1'b0);
        a = -36'sd384;
        send_one("n384_m0", {{(VW-W){1'b0}}, a}, 2'b00, 32'hFFFFFFFE, 1'b0);
        send_one("n384_m1", {{(VW-W){1'b0}}, a}, 2'b01, 32'hFFFFFFFF, 1'b0);
        send_one("n384_m2", {{(VW-W){1'b0}}, a}, 2'b10, 32'hFFFFFFFF, 1'b0);
        send_one("n384_m3", {{(VW-W){1'b0}}, a}, 2'b11, 32'hFFFFFFFE, 1'b0);
        send_one("sat_pos", fill(36'h7FFFFFFFF), 2'b00, 32'h7FFFFFFF, 1'b1);
        send_one("sat_neg", fill(36'h800000000), 2'b00, 32'h80000000, 1'b1);

        sb_on = 1'b1;
        n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data = rand_vec();
            in_mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("b2b_count", n_out, 20);
        check("b2b_span", last_out - first_out, 19);
        check("b2b_left", exp_q.size(), 0);

        n_out = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = rand_vec();
            in_mode = 2'($urandom_range(0, 3));
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            if (!acc) check("rand_stuck", 0, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("rand_count", n_out, 100);
        check("rand_left", exp_q.size(), 0);
        sb_on = 1'b0;

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = fill(W'(i + 1));
            in_mode = 2'b00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ovf", out_ovf, 0);
        in_data = fill(36'd256);
        in_mode = 2'b00;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("post_rst_lat", cyc, 6);
        check("post_rst_d", out_data, 32);
        @(posedge clk); #1;
        stale = 0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            stale += int'(out_valid);
        end
        check("stale", stale, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
